// File: rtl/dma_addr_seq_if.sv
// dma_addr_seq_if -- memory request channel of the DMA address sequencer.
//   mem_req  : sequencer has a request outstanding (master -> slave)
//   mem_addr : address of the outstanding request   (master -> slave)
//   mem_ack  : memory accepts the current request   (slave -> master)
interface dma_addr_seq_if #(
    parameter int AW = 16
);
    logic          mem_req;
    logic [AW-1:0] mem_addr;
    logic          mem_ack;

    modport master (
        output mem_req,
        output mem_addr,
        input  mem_ack
    );

    modport slave (
        input  mem_req,
        input  mem_addr,
        output mem_ack
    );
endinterface

// File: rtl/dma_addr_seq.sv
// dma_addr_seq -- 2-D DMA address sequencer.
// The state machine is split in two. An upstream block decides the next state.
// This block holds the present state and the address and count registers. It
// also applies the address-control action that the upstream block selects.
// Ports:
//   clk, rst            : clock, asynchronous active-high reset
//   bus (master)        : mem_req / mem_addr out, mem_ack in
//   dmnst_b[3:0]        : next-state code from the upstream logic
//   adctlp_b[2:0]       : address-control code from the upstream logic
//   start               : begin a transfer (sampled only when idle)
//   cfg_base/stride     : start address and row stride (AW bits)
//   cfg_xlen/ylen       : x / y lengths (CW bits)
//   rmw_req             : transfer is read-modify-write
//   dmpst[3:0]          : registered present state, fed back upstream
//   xskip, yskip, page  : status flags for the upstream logic
//   rmwB                : active-low read-modify-write flag
//   busy, done          : transfer active / one-cycle completion pulse
module dma_addr_seq #(
    parameter int AW = 16,
    parameter int CW = 8
) (
    input  logic          clk,
    input  logic          rst,
    dma_addr_seq_if.master bus,
    input  logic [3:0]    dmnst_b,
    input  logic [2:0]    adctlp_b,
    input  logic          start,
    input  logic [AW-1:0] cfg_base,
    input  logic [AW-1:0] cfg_stride,
    input  logic [CW-1:0] cfg_xlen,
    input  logic [CW-1:0] cfg_ylen,
    input  logic          rmw_req,
    output logic [3:0]    dmpst,
    output logic          xskip,
    output logic          yskip,
    output logic          page,
    output logic          rmwB,
    output logic          busy,
    output logic          done
);

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t        state_q,   state_d;
    logic [3:0]    dmpst_q,   dmpst_d;
    logic [AW-1:0] addr_q,    addr_d;
    logic [AW-1:0] rowbase_q, rowbase_d;
    logic [CW-1:0] xcnt_q,    xcnt_d;
    logic [CW-1:0] ycnt_q,    ycnt_d;
    logic [AW-1:0] base_q,    base_d;
    logic [AW-1:0] stride_q,  stride_d;
    logic [CW-1:0] xlen_q,    xlen_d;
    logic [CW-1:0] ylen_q,    ylen_d;
    logic          rmw_q,     rmw_d;
    logic          done_q,    done_d;

    logic          run;
    logic          advance;
    logic [AW-1:0] next_row;
    logic [AW-1:0] next_page;

    assign run      = (state_q == RUN);
    // mem_ack is qualified by RUN so it has no effect while idle.
    assign advance  = run && bus.mem_ack;
    assign next_row = rowbase_q + stride_q;
    // Forcing the low byte to FF before the increment carries into the
    // page bits and leaves the low byte at 00.
    assign next_page = {addr_q[AW-1:8], 8'hFF} + AW'(1);

    always_comb begin
        state_d   = state_q;
        dmpst_d   = dmpst_q;
        addr_d    = addr_q;
        rowbase_d = rowbase_q;
        xcnt_d    = xcnt_q;
        ycnt_d    = ycnt_q;
        base_d    = base_q;
        stride_d  = stride_q;
        xlen_d    = xlen_q;
        ylen_d    = ylen_q;
        rmw_d     = rmw_q;
        done_d    = 1'b0;

        case (state_q)
            IDLE: begin
                if (start) begin
                    base_d    = cfg_base;
                    stride_d  = cfg_stride;
                    xlen_d    = cfg_xlen;
                    ylen_d    = cfg_ylen;
                    rmw_d     = rmw_req;
                    addr_d    = cfg_base;
                    rowbase_d = cfg_base;
                    xcnt_d    = '0;
                    ycnt_d    = '0;
                    dmpst_d   = 4'b0001;
                    state_d   = RUN;
                end
            end
            RUN: begin
                if (advance) begin
                    dmpst_d = dmnst_b;
                    case (adctlp_b)
                        3'b001: begin
                            addr_d = addr_q + AW'(1);
                            xcnt_d = xcnt_q + CW'(1);
                        end
                        3'b010: begin
                            rowbase_d = next_row;
                            addr_d    = next_row;
                            xcnt_d    = '0;
                            ycnt_d    = ycnt_q + CW'(1);
                        end
                        3'b011: begin
                            addr_d    = base_q;
                            rowbase_d = base_q;
                            xcnt_d    = '0;
                            ycnt_d    = '0;
                        end
                        3'b100: addr_d = next_page;
                        default: ;
                    endcase
                    // Next state 0 ends the transfer. The action above still applies.
                    if (dmnst_b == 4'b0000) begin
                        state_d = IDLE;
                        done_d  = 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            dmpst_q   <= '0;
            addr_q    <= '0;
            rowbase_q <= '0;
            xcnt_q    <= '0;
            ycnt_q    <= '0;
            base_q    <= '0;
            stride_q  <= '0;
            xlen_q    <= '0;
            ylen_q    <= '0;
            rmw_q     <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            dmpst_q   <= dmpst_d;
            addr_q    <= addr_d;
            rowbase_q <= rowbase_d;
            xcnt_q    <= xcnt_d;
            ycnt_q    <= ycnt_d;
            base_q    <= base_d;
            stride_q  <= stride_d;
            xlen_q    <= xlen_d;
            ylen_q    <= ylen_d;
            rmw_q     <= rmw_d;
            done_q    <= done_d;
        end
    end

    // Every output is decoded from flops only. The count flags are gated by RUN.
    // This keeps them low in reset and in idle, where the zeroed counters
    // would otherwise compare equal.
    assign bus.mem_req  = run;
    assign bus.mem_addr = addr_q;
    assign busy         = run;
    assign done         = done_q;
    assign dmpst        = dmpst_q;
    assign xskip        = run && (xcnt_q == xlen_q);
    assign yskip        = run && (ycnt_q == ylen_q);
    assign page         = (addr_q[7:0] == 8'hFF);
    assign rmwB         = ~(run && rmw_q);

endmodule
